// File: rtl/testport_capture.sv
`default_nettype none
// ============================================================================
//  Module   : testport_capture
//  Purpose  : Snoops committed processor stores to the simulation test port,
//             frames them into a BEGIN/END session and streams one
//             {data, index} record per store through a small FWFT FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module testport_capture #(
  parameter logic [29:0] TEST_PORT    = 30'h3FF,
  parameter logic [31:0] BEGIN_SYMBOL = 32'h00000168,
  parameter logic [31:0] END_SYMBOL   = 32'h00000D5D,
  parameter int          DEPTH        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] proc_addr,
  input  logic [31:0] proc_wdata,
  input  logic        proc_write,
  input  logic        proc_stall,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [11:0] out_index,
  output logic [15:0] cycles,
  output logic        active,
  output logic        done,
  output logic        overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int REC_W = 32 + 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [11:0]       index_q, index_d;
  logic [15:0]       cycles_q, cycles_d;
  logic              overflow_q, overflow_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [REC_W-1:0]  mem_q [DEPTH];
  logic [REC_W-1:0]  mem_d [DEPTH];

  logic commit;
  logic push;
  logic pop;
  logic accept;
  logic fifo_full;
  logic fifo_empty;

  // A store counts once: only on the cycle the D-cache lets it through.
  assign commit     = proc_write && !proc_stall && (proc_addr == TEST_PORT);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign pop        = !fifo_empty && out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign accept     = push && (!fifo_full || pop);

  // Session FSM, store ordinal, RUN cycle counter and sticky overflow flag.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    cycles_d   = cycles_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit && (proc_wdata == BEGIN_SYMBOL)) begin
          state_d  = ST_RUN;
          index_d  = '0;
          cycles_d = '0;
        end
      end
      ST_RUN: begin
        if (cycles_q != 16'hFFFF) begin
          cycles_d = cycles_q + 16'd1;
        end
        if (commit) begin
          push    = 1'b1;
          // Ordinal advances even on a dropped push so the consumer sees a gap.
          index_d = index_q + 12'd1;
          if (proc_wdata == END_SYMBOL) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      mem_d[wr_ptr_q] = {proc_wdata, index_q};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      cycles_q   <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      cycles_q   <= cycles_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  // Head entry is presented first-word-fall-through; zero when nothing is held.
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? 32'd0 : mem_q[rd_ptr_q][REC_W-1:12];
  assign out_index = fifo_empty ? 12'd0 : mem_q[rd_ptr_q][11:0];
  assign cycles    = cycles_q;
  assign active    = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_testport_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_testport_capture
//  Purpose  : Self-checking bench for testport_capture against a queue-based
//             behavioural model of the session and record stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_testport_capture;

  localparam logic [29:0] TP    = 30'h3FF;
  localparam logic [31:0] BEGS  = 32'h00000168;
  localparam logic [31:0] ENDS  = 32'h00000D5D;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [29:0] proc_addr;
  logic [31:0] proc_wdata;
  logic        proc_write;
  logic        proc_stall;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [11:0] out_index;
  logic [15:0] cycles;
  logic        active;
  logic        done;
  logic        overflow;

  testport_capture #(
    .TEST_PORT   (TP),
    .BEGIN_SYMBOL(BEGS),
    .END_SYMBOL  (ENDS),
    .DEPTH       (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .proc_addr (proc_addr),
    .proc_wdata(proc_wdata),
    .proc_write(proc_write),
    .proc_stall(proc_stall),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .cycles    (cycles),
    .active    (active),
    .done      (done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [11:0] idx;
  } rec_t;

  // Behavioural model: session phase 0=idle 1=run 2=done, queue of held records.
  rec_t q[$];
  rec_t popped[$];
  int   m_state;
  int   m_idx;
  int   m_cyc;
  int   m_ovf;
  logic m_commit;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [43:0] pw(input int k);
    if (k < popped.size()) return {popped[k].data, popped[k].idx};
    return '1;
  endfunction

  // Model update: one step per rising edge, reset asynchronously.
  initial begin
    m_state = 0; m_idx = 0; m_cyc = 0; m_ovf = 0; m_commit = 1'b0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete(); popped.delete();
        m_state = 0; m_idx = 0; m_cyc = 0; m_ovf = 0;
      end else begin
        m_commit = proc_write && !proc_stall && (proc_addr == TP);
        if (q.size() != 0 && out_ready) popped.push_back(q.pop_front());
        if (m_state == 0) begin
          if (m_commit && proc_wdata == BEGS) begin
            m_state = 1; m_idx = 0; m_cyc = 0;
          end
        end else if (m_state == 1) begin
          if (m_cyc < 65535) m_cyc++;
          if (m_commit) begin
            if (q.size() < DEPTH) q.push_back('{data: proc_wdata, idx: 12'(m_idx)});
            else m_ovf = 1;
            m_idx = (m_idx + 1) % 4096;
            if (proc_wdata == ENDS) m_state = 2;
          end
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    logic [31:0] ed;
    logic [11:0] ei;
    forever begin
      @(negedge clk);
      ed = '0; ei = '0;
      if (q.size() != 0) begin ed = q[0].data; ei = q[0].idx; end
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("out_data",  64'(out_data),  64'(ed));
      check("out_index", 64'(out_index), 64'(ei));
      check("cycles",    64'(cycles),    64'(m_cyc));
      check("active",    64'(active),    64'(m_state == 1));
      check("done",      64'(done),      64'(m_state == 2));
      check("overflow",  64'(overflow),  64'(m_ovf));
    end
  end

  task automatic drive(input logic w, input logic [29:0] a, input logic [31:0] d,
                       input logic s, input logic r);
    @(negedge clk); #1;
    proc_write = w; proc_addr = a; proc_wdata = d; proc_stall = s; out_ready = r;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b0; proc_write = 1'b0; proc_stall = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk); #2;
  endtask

  logic [31:0] seq1 [7] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'hD5D};

  initial begin
    int rp;
    int r;
    logic [31:0] d;
    logic [29:0] a;
    rst = 1'b0; proc_addr = '0; proc_wdata = '0; proc_write = 1'b0;
    proc_stall = 1'b0; out_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #2;
    check("rst_valid",  64'(out_valid), 64'd0);
    check("rst_data",   64'(out_data),  64'd0);
    check("rst_index",  64'(out_index), 64'd0);
    check("rst_cycles", 64'(cycles),    64'd0);
    check("rst_active", 64'(active),    64'd0);
    check("rst_done",   64'(done),      64'd0);
    check("rst_ovf",    64'(overflow),  64'd0);
    @(negedge clk); #1; rst = 1'b1;

    // Basic session with pre/post filtering
    drive(1, TP, 32'd9, 0, 1);
    drive(1, TP, BEGS, 0, 1);
    for (int i = 0; i < 7; i++) drive(1, TP, seq1[i], 0, 1);
    drive(1, TP, 32'd3, 0, 1);
    repeat (4) drive(0, TP, 32'd0, 0, 1);
    settle();
    check("basic_count", 64'(popped.size()), 64'd7);
    for (int i = 0; i < 7; i++) check("basic_rec", 64'(pw(i)), 64'({seq1[i], 12'(i)}));
    check("basic_cycles", 64'(cycles), 64'd7);
    check("basic_done", 64'(done), 64'd1);
    check("basic_ovf", 64'(overflow), 64'd0);

    // Stall filter and foreign address
    do_reset();
    drive(1, TP, BEGS, 0, 1);
    repeat (3) drive(1, TP, 32'd5, 1, 1);
    drive(1, TP, 32'd5, 0, 1);
    drive(1, 30'h3FE, 32'd7, 0, 1);
    repeat (3) drive(0, TP, 32'd0, 0, 1);
    settle();
    check("stall_count", 64'(popped.size()), 64'd1);
    check("stall_rec", 64'(pw(0)), 64'({32'd5, 12'd0}));

    // Backpressure and overflow
    do_reset();
    drive(1, TP, BEGS, 0, 0);
    for (int i = 0; i < 6; i++) drive(1, TP, 32'(100 + i), 0, 0);
    drive(0, TP, 32'd0, 0, 0);
    settle();
    check("ovf_held", 64'(q.size()), 64'd4);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_head", 64'(out_index), 64'd0);
    repeat (4) drive(0, TP, 32'd0, 0, 1);
    drive(1, TP, 32'd200, 0, 1);
    repeat (3) drive(0, TP, 32'd0, 0, 1);
    settle();
    check("ovf_count", 64'(popped.size()), 64'd5);
    for (int i = 0; i < 4; i++) check("ovf_rec", 64'(pw(i)), 64'({32'(100 + i), 12'(i)}));
    check("ovf_gap", 64'(pw(4)), 64'({32'd200, 12'd6}));

    // Full FIFO with simultaneous push and pop
    do_reset();
    drive(1, TP, BEGS, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, TP, 32'(10 + i), 0, 0);
    drive(1, TP, 32'd14, 0, 1);
    drive(0, TP, 32'd0, 0, 0);
    settle();
    check("fullpp_held", 64'(q.size()), 64'd4);
    check("fullpp_ovf", 64'(overflow), 64'd0);
    check("fullpp_head", 64'({out_data, out_index}), 64'({32'd11, 12'd1}));
    check("fullpp_popped", 64'(pw(0)), 64'({32'd10, 12'd0}));

    // Reset mid-run
    do_reset();
    drive(1, TP, BEGS, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, TP, 32'(50 + i), 0, 0);
    drive(0, TP, 32'd0, 0, 0);
    @(negedge clk); #3;
    rst = 1'b0;
    #1;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_active", 64'(active), 64'd0);
    check("mrst_cycles", 64'(cycles), 64'd0);
    @(negedge clk); #1; rst = 1'b1;
    drive(1, TP, BEGS, 0, 1);
    drive(1, TP, 32'd77, 0, 1);
    repeat (3) drive(0, TP, 32'd0, 0, 1);
    settle();
    check("mrst_restart", 64'(pw(0)), 64'({32'd77, 12'd0}));

    // Randomized traffic with periodic resets and varying backpressure
    rp = 90;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) begin
        do_reset();
        rp = $urandom_range(10, 100);
      end
      r = $urandom_range(0, 99);
      if (r < 5) d = BEGS;
      else if (r < 7) d = ENDS;
      else d = $urandom_range(0, 4095);
      a = ($urandom_range(0, 9) == 0) ? 30'h3FE : TP;
      drive(($urandom_range(0, 3) != 0), a, d, ($urandom_range(0, 3) == 0),
            ($urandom_range(1, 100) <= rp));
    end
    repeat (6) drive(0, TP, 32'd0, 0, 1);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
